// File: rtl/sdram_rom_arbiter.sv
// sdram_rom_arbiter: shares one SDRAM port between the ioctl ROM download packer and NUM_PORTS round-robin read clients
module sdram_rom_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ioctl_download,
  input  logic                            ioctl_wr,
  input  logic [ADDR_WIDTH+1:0]           ioctl_addr,
  input  logic [7:0]                      ioctl_data,
  input  logic [NUM_PORTS-1:0]            port_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  output logic [NUM_PORTS-1:0]            port_valid,
  output logic [31:0]                     port_q,
  output logic                            dl_overrun,
  output logic [ADDR_WIDTH-1:0]           sdram_addr,
  output logic [31:0]                     sdram_data,
  output logic                            sdram_we,
  output logic                            sdram_req,
  input  logic                            sdram_ack,
  input  logic                            sdram_valid,
  input  logic [31:0]                     sdram_q
);
  localparam int AW = ADDR_WIDTH;
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef enum logic [1:0] {IDLE, REQ, RD} state_t;
  state_t state_q, state_d;
  logic req_q, req_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] data_q, data_d, rdata_q, rdata_d;
  logic [IW-1:0] grant_q, grant_d, rr_q, rr_d, sel, idx;
  logic hit;
  logic [NUM_PORTS-1:0] pending_q, pending_d, pvalid_q, pvalid_d, clr;
  logic [AW-1:0] paddr_q [NUM_PORTS];
  logic [AW-1:0] paddr_d [NUM_PORTS];
  logic dl_q;
  logic [31:0] pk_data_q, pk_data_d, done_data;
  logic [3:0] pk_lanes_q, pk_lanes_d;
  logic [AW-1:0] pk_addr_q, pk_addr_d, done_addr;
  logic [1:0] lane;
  logic done, flush, pop;
  logic wq_valid_q, wq_valid_d, ovr_q, ovr_d;
  logic [AW-1:0] wq_addr_q, wq_addr_d;
  logic [31:0] wq_data_q, wq_data_d;
  assign lane  = ioctl_addr[1:0];
  assign flush = dl_q && !ioctl_download && |pk_lanes_q;
  always_comb begin
    pk_data_d  = pk_data_q;
    pk_lanes_d = pk_lanes_q;
    pk_addr_d  = pk_addr_q;
    done       = 1'b0;
    done_addr  = pk_addr_q;
    done_data  = pk_data_q;
    if (ioctl_wr) begin
      pk_data_d[{lane, 3'b000} +: 8] = ioctl_data;
      pk_lanes_d[lane]               = 1'b1;
      pk_addr_d                      = ioctl_addr[AW+1:2];
      if (lane == 2'd3) begin
        done       = 1'b1;
        done_addr  = ioctl_addr[AW+1:2];
        done_data  = pk_data_d;
        pk_data_d  = '0;
        pk_lanes_d = '0;
      end
    end else if (flush) begin
      done       = 1'b1;
      pk_data_d  = '0;
      pk_lanes_d = '0;
    end
  end
  // The FSM takes the queued word the cycle it leaves IDLE, so the entry is free while that write is in flight
  always_comb begin
    wq_valid_d = wq_valid_q && !pop;
    wq_addr_d  = wq_addr_q;
    wq_data_d  = wq_data_q;
    ovr_d      = ovr_q;
    if (done) begin
      if (wq_valid_d) ovr_d = 1'b1;
      else begin
        wq_valid_d = 1'b1;
        wq_addr_d  = done_addr;
        wq_data_d  = done_data;
      end
    end
  end
  always_comb begin
    sel = rr_q;
    hit = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = IW'((int'(rr_q) + k) % NUM_PORTS);
      if (!hit && pending_q[idx]) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    rdata_d  = rdata_q;
    pvalid_d = '0;
    clr      = '0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (wq_valid_q) begin
          pop     = 1'b1;
          addr_d  = wq_addr_q;
          data_d  = wq_data_q;
          we_d    = 1'b1;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (!ioctl_download && hit) begin
          grant_d = sel;
          rr_d    = sel;
          addr_d  = paddr_q[sel];
          data_d  = '0;
          we_d    = 1'b0;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = we_q ? IDLE : RD;
        end
      end
      RD: begin
        if (sdram_valid) begin
          rdata_d           = sdram_q;
          pvalid_d[grant_q] = 1'b1;
          clr[grant_q]      = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pending_d = (pending_q & ~clr) | port_req;
    for (int i = 0; i < NUM_PORTS; i++)
      paddr_d[i] = port_req[i] ? port_addr[i*AW +: AW] : paddr_q[i];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      rr_q       <= IW'(NUM_PORTS - 1);
      rdata_q    <= '0;
      pvalid_q   <= '0;
      pending_q  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) paddr_q[i] <= '0;
      dl_q       <= 1'b0;
      pk_data_q  <= '0;
      pk_lanes_q <= '0;
      pk_addr_q  <= '0;
      wq_valid_q <= 1'b0;
      wq_addr_q  <= '0;
      wq_data_q  <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      rdata_q    <= rdata_d;
      pvalid_q   <= pvalid_d;
      pending_q  <= pending_d;
      for (int i = 0; i < NUM_PORTS; i++) paddr_q[i] <= paddr_d[i];
      dl_q       <= ioctl_download;
      pk_data_q  <= pk_data_d;
      pk_lanes_q <= pk_lanes_d;
      pk_addr_q  <= pk_addr_d;
      wq_valid_q <= wq_valid_d;
      wq_addr_q  <= wq_addr_d;
      wq_data_q  <= wq_data_d;
      ovr_q      <= ovr_d;
    end
  end
  assign sdram_req  = req_q;
  assign sdram_we   = we_q;
  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign port_valid = pvalid_q;
  assign port_q     = rdata_q;
  assign dl_overrun = ovr_q;
endmodule

// File: tb/tb_sdram_rom_arbiter.sv
// tb_sdram_rom_arbiter: directed checks of download packing, write queue, round-robin reads and reset
module tb_sdram_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 23;
  logic clk = 1'b0;
  logic reset, ioctl_download, ioctl_wr, sdram_we, sdram_req, sdram_ack, sdram_valid, dl_overrun;
  logic [AW+1:0] ioctl_addr;
  logic [7:0] ioctl_data;
  logic [N-1:0] port_req, port_valid;
  logic [N*AW-1:0] port_addr;
  logic [31:0] port_q, sdram_data, sdram_q;
  logic [AW-1:0] sdram_addr;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  sdram_rom_arbiter #(.NUM_PORTS(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .port_req(port_req), .port_addr(port_addr),
    .port_valid(port_valid), .port_q(port_q), .dl_overrun(dl_overrun), .sdram_addr(sdram_addr),
    .sdram_data(sdram_data), .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .sdram_valid(sdram_valid), .sdram_q(sdram_q)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_req();
    for (int i = 0; i < 20 && !sdram_req; i++) tick();
    chk("req_seen", 64'(sdram_req), 64'(1));
  endtask
  task automatic wr_byte(input logic [AW+1:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    tick();
    ioctl_wr = 1'b0;
  endtask
  task automatic ack_once();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
  endtask
  task automatic serve(input int g, input logic [AW-1:0] a, input logic [31:0] q);
    wait_req();
    chk("rd_addr", 64'(sdram_addr), 64'(a));
    chk("rd_we", 64'(sdram_we), 64'(0));
    ack_once();
    tick();
    sdram_valid = 1'b1;
    sdram_q = q;
    tick();
    sdram_valid = 1'b0;
    chk("rd_valid", 64'(port_valid), 64'(1 << g));
    chk("rd_q", 64'(port_q), 64'(q));
  endtask
  task automatic pulse_all();
    for (int i = 0; i < N; i++) port_addr[i*AW +: AW] = AW'(32'h200 + i);
    port_req = '1;
    tick();
    port_req = '0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    port_req = '0; port_addr = '0; sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_req", 64'(sdram_req), 64'(0));
    chk("rst_we", 64'(sdram_we), 64'(0));
    chk("rst_addr", 64'(sdram_addr), 64'(0));
    chk("rst_pvalid", 64'(port_valid), 64'(0));
    chk("rst_q", 64'(port_q), 64'(0));
    chk("rst_ovr", 64'(dl_overrun), 64'(0));
    // single read on port 1, fixed latencies
    port_addr[1*AW +: AW] = 23'h000100;
    port_req = 4'b0010;
    tick();
    port_req = '0;
    chk("t1_c1_req", 64'(sdram_req), 64'(0));
    tick();
    chk("t1_c2_req", 64'(sdram_req), 64'(1));
    chk("t1_c2_we", 64'(sdram_we), 64'(0));
    chk("t1_c2_addr", 64'(sdram_addr), 64'(32'h100));
    tick();
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("t1_c5_req", 64'(sdram_req), 64'(0));
    tick();
    tick();
    sdram_valid = 1'b1;
    sdram_q = 32'hDEADBEEF;
    tick();
    sdram_valid = 1'b0;
    chk("t1_c8_valid", 64'(port_valid), 64'(4'b0010));
    chk("t1_c8_q", 64'(port_q), 64'(32'hDEADBEEF));
    tick();
    chk("t1_c9_valid", 64'(port_valid), 64'(0));
    // full word download
    ioctl_download = 1'b1;
    wr_byte(27'h10, 8'h11);
    wr_byte(27'h11, 8'h22);
    wr_byte(27'h12, 8'h33);
    wr_byte(27'h13, 8'h44);
    tick();
    chk("t2_req", 64'(sdram_req), 64'(1));
    chk("t2_we", 64'(sdram_we), 64'(1));
    chk("t2_addr", 64'(sdram_addr), 64'(4));
    chk("t2_data", 64'(sdram_data), 64'(32'h44332211));
    tick();
    tick();
    chk("t2_hold_req", 64'(sdram_req), 64'(1));
    chk("t2_hold_we", 64'(sdram_we), 64'(1));
    ack_once();
    chk("t2_req_drop", 64'(sdram_req), 64'(0));
    // partial word flushed by download end
    wr_byte(27'h20, 8'hAA);
    wr_byte(27'h21, 8'hBB);
    chk("t3_noreq", 64'(sdram_req), 64'(0));
    ioctl_download = 1'b0;
    tick();
    tick();
    chk("t3_req", 64'(sdram_req), 64'(1));
    chk("t3_we", 64'(sdram_we), 64'(1));
    chk("t3_addr", 64'(sdram_addr), 64'(8));
    chk("t3_data", 64'(sdram_data), 64'(32'h0000BBAA));
    ack_once();
    // round robin from reset pointer, twice
    do_reset();
    pulse_all();
    for (int g = 0; g < N; g++) serve(g, AW'(32'h200 + g), 32'hA000_0000 + g);
    pulse_all();
    for (int g = 0; g < N; g++) serve(g, AW'(32'h200 + g), 32'hB000_0000 + g);
    // ack stalled while three words complete
    ioctl_download = 1'b1;
    for (int b = 0; b < 4; b++) wr_byte(27'h40 + b, 8'h10 + 8'(b));
    wait_req();
    chk("t5_addr0", 64'(sdram_addr), 64'(32'h10));
    for (int b = 0; b < 4; b++) wr_byte(27'h44 + b, 8'h20 + 8'(b));
    for (int b = 0; b < 4; b++) wr_byte(27'h48 + b, 8'h30 + 8'(b));
    tick();
    chk("t5_ovr", 64'(dl_overrun), 64'(1));
    for (int i = 0; i < 180; i++) tick();
    chk("t5_stall_req", 64'(sdram_req), 64'(1));
    chk("t5_stall_addr", 64'(sdram_addr), 64'(32'h10));
    chk("t5_data0", 64'(sdram_data), 64'(32'h13121110));
    ack_once();
    wait_req();
    chk("t5_addr1", 64'(sdram_addr), 64'(32'h11));
    chk("t5_data1", 64'(sdram_data), 64'(32'h23222120));
    chk("t5_we1", 64'(sdram_we), 64'(1));
    ack_once();
    for (int i = 0; i < 5; i++) tick();
    chk("t5_no_third", 64'(sdram_req), 64'(0));
    chk("t5_ovr_sticky", 64'(dl_overrun), 64'(1));
    ioctl_download = 1'b0;
    tick();
    tick();
    chk("t5_no_flush", 64'(sdram_req), 64'(0));
    // reset while waiting for read data
    port_addr[2*AW +: AW] = 23'h000300;
    port_req = 4'b0100;
    tick();
    port_req = '0;
    wait_req();
    chk("t6_addr", 64'(sdram_addr), 64'(32'h300));
    ack_once();
    tick();
    reset = 1'b1;
    tick();
    chk("t6_req", 64'(sdram_req), 64'(0));
    chk("t6_pvalid", 64'(port_valid), 64'(0));
    chk("t6_ovr", 64'(dl_overrun), 64'(0));
    reset = 1'b0;
    tick();
    sdram_valid = 1'b1;
    sdram_q = 32'h12345678;
    tick();
    sdram_valid = 1'b0;
    chk("t6_ignored_valid", 64'(port_valid), 64'(0));
    tick();
    tick();
    chk("t6_idle_req", 64'(sdram_req), 64'(0));
    chk("t6_q", 64'(port_q), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
